mfp_io_debounce: RTL
====================

# mfp_io_debounce

Input conditioning stage that sits directly upstream of the AHB GPIO register block. It synchronizes the raw board pushbuttons and slide switches into the HCLK domain and debounces each bit independently using a shared millisecond tick and per-bit stability counters. It drives clean `pbtn_db` / `swtch_db` levels, which the GPIO block returns on AHB reads. It also produces one-cycle press/release pulses for pushbuttons.

## Interface
Parameters:
- `N_PB`, default 6: pushbutton width (board buttons plus the reset button in the MSB).
- `N_SW`, default 16: switch width.
- `TICK_DIV`, default 50000: HCLK cycles per debounce tick (1 ms at 50 MHz). Legal range is 1..65535.
- `DB_TICKS`, default 5: consecutive stable ticks required to accept a new level. Legal range is 1..15.
- `PB_INIT`, default all-0: reset value of `pbtn_db`.
- `SW_INIT`, default all-0: reset value of `swtch_db`.

Ports:
- `HCLK`  in  1  system clock.
- `HRESET`  in  1  reset, asynchronous, active-high. Asserts immediately and is released synchronously by the system reset logic.
- `pbtn_in`  in  N_PB  raw asynchronous pushbutton levels.
- `switch_in`  in  N_SW  raw asynchronous switch levels.
- `pbtn_db`  out  N_PB  debounced pushbutton levels, registered.
- `swtch_db`  out  N_SW  debounced switch levels, registered.
- `pbtn_rise`  out  N_PB  one-cycle pulse when `pbtn_db` bit goes 0->1.
- `pbtn_fall`  out  N_PB  one-cycle pulse when `pbtn_db` bit goes 1->0.
- `tick`  out  1  prescaler tick strobe, exported for debug and test.

## Operation
- Synchronizer: two flops per input bit (`sync1`, `sync2`). `sync2` is the only value the debounce logic uses. Both flops reset to the corresponding INIT bit.
- Prescaler: a 16-bit counter `pre` counts 0..TICK_DIV-1 and wraps to 0. `tick` = (`pre` == TICK_DIV-1). With TICK_DIV=1, `tick` is constantly 1.
- Per-bit debouncer: a 4-bit counter `cnt`, one per bit, with two states.
  - STABLE (`sync2` == db): `cnt` is held at 0.
  - PENDING (`sync2` != db):
    - On `tick`, `cnt` increments.
    - On `tick` with `cnt` == DB_TICKS-1, db toggles to `sync2` at that edge and `cnt` clears.
    - If `sync2` returns to db in any cycle, tick or not, `cnt` clears that cycle and the bit is back in STABLE.
- Edge outputs: `pbtn_rise[i]` = db goes 0->1 on this edge, registered and high for exactly one cycle. `pbtn_fall` is the same for 1->0. Both outputs are registered in parallel with the db update, so each is high in the same cycle as the new db value.
- Bits are fully independent. Simultaneous changes on several bits each follow their own counter.
- Reset, asynchronous and effective at any time including mid-count:
  - `pbtn_db` = PB_INIT and `swtch_db` = SW_INIT.
  - `pbtn_rise` = `pbtn_fall` = 0.
  - All `cnt` = 0, `pre` = 0, `tick` = 0.
  - No edge pulses are emitted on reset assertion or release.

## Timing
- Define latency as the time from a raw input change, setup-met before edge E0, to the db output update.
  - Minimum latency is (DB_TICKS-1)·TICK_DIV + 3 cycles.
  - Maximum latency is DB_TICKS·TICK_DIV + 2 cycles.
  - The exact value depends on the tick phase.
- With TICK_DIV=1, latency is exactly DB_TICKS + 2 cycles.
- Glitch rejection: any excursion seen at `sync2` for fewer than (DB_TICKS-1)·TICK_DIV + 1 cycles never reaches db. In the default configuration that means any excursion under 4 ms.
- An excursion that crosses a tick then reverts still clears `cnt`. There is no accumulation across bounces.
- The prescaler free-runs and is never stalled by input activity.
- All outputs are flops and there is no combinational path from input to output.

## Test plan
- Reset values: set PB_INIT=6'b100000 and assert HRESET mid-count. Required: outputs = INIT in the same cycle with no clock needed, `cnt`/`pre` = 0, no rise/fall pulse after release.
- Clean press: set TICK_DIV=4, DB_TICKS=3, `pbtn_in[0]` 0->1 and hold. Required: `pbtn_db[0]` = 1 within 11..14 cycles, `pbtn_rise[0]` high for exactly 1 cycle coincident with it, and `pbtn_fall` stays 0.
- Bounce rejection: same params, drive `switch_in[3]` as a 1-cycle pulse, then a 8-cycle pulse. Required: `swtch_db[3]` stays 0 throughout and `cnt` returns to 0.
- Bounce then settle: toggle `pbtn_in[2]` every 5 cycles ×6, then hold at 1. Required: exactly one 0->1 transition on `pbtn_db[2]`, occurring 11..14 cycles after the final change.
- Simultaneous bits: set TICK_DIV=1, DB_TICKS=5, switch all 16 `switch_in` bits to 16'hA5C3 in one cycle. Required: `swtch_db` = 16'hA5C3 exactly 7 cycles later with all bits updating in the same cycle.
- Release pulse and wrap: with default params, release a held button. Required: `pbtn_fall` is a single pulse, and `tick` period is 50000 cycles with `pre` wrapping 49999->0.

Source files
------------

// File: rtl/mfp_io_debounce.sv
// rtl/mfp_io_debounce.sv - two-flop synchronizer plus per-bit tick-based debouncer
// for pushbuttons and switches, with registered press/release pulses.
module mfp_io_debounce #(
  parameter int                N_PB     = 6,
  parameter int                N_SW     = 16,
  parameter int                TICK_DIV = 50000,
  parameter int                DB_TICKS = 5,
  parameter logic [N_PB-1:0]   PB_INIT  = '0,
  parameter logic [N_SW-1:0]   SW_INIT  = '0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [N_PB-1:0] pbtn_in,
  input  logic [N_SW-1:0] switch_in,
  output logic [N_PB-1:0] pbtn_db,
  output logic [N_SW-1:0] swtch_db,
  output logic [N_PB-1:0] pbtn_rise,
  output logic [N_PB-1:0] pbtn_fall,
  output logic            tick
);

  localparam int          N        = N_PB + N_SW;
  localparam logic [N-1:0] INIT    = {SW_INIT, PB_INIT};
  localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  CNT_LAST = 4'(DB_TICKS - 1);

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] db;
  logic [N-1:0] accept;
  logic [3:0]   cnt [N];
  logic [15:0]  pre;
  logic [15:0]  pre_next;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1 <= INIT;
      sync2 <= INIT;
    end else begin
      sync1 <= {switch_in, pbtn_in};
      sync2 <= sync1;
    end
  end

  always_comb begin
    pre_next = (pre == PRE_LAST) ? 16'd0 : pre + 16'd1;
  end

  // tick is registered from pre_next so it equals (pre == TICK_DIV-1) yet is 0 in reset
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pre  <= 16'd0;
      tick <= 1'b0;
    end else begin
      pre  <= pre_next;
      tick <= (pre_next == PRE_LAST);
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = (sync2[i] != db[i]) && tick && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      db        <= INIT;
      pbtn_rise <= '0;
      pbtn_fall <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= 4'd0;
      end
    end else begin
      db        <= db ^ accept;
      pbtn_rise <= accept[N_PB-1:0] & sync2[N_PB-1:0];
      pbtn_fall <= accept[N_PB-1:0] & ~sync2[N_PB-1:0];
      for (int i = 0; i < N; i++) begin
        if ((sync2[i] == db[i]) || accept[i]) begin
          cnt[i] <= 4'd0;
        end else if (tick) begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  assign pbtn_db  = db[N_PB-1:0];
  assign swtch_db = db[N-1:N_PB];

endmodule
